// File: rtl/dma_block_controller_if.sv
// -----------------------------------------------------------------------------
// dma_block_controller_if
// Groups the command, bus-arbitration and memory-side signals of the DMA block
// controller.
//   master : the controller itself (takes commands, grant and memory ready;
//            drives bus request, block address/offset, write strobe, status).
//   slave  : the surrounding system (CPU, memory, device side).
// Signals:
//   cmd_valid, cmd_addr, cmd_length : one-cycle start command from the CPU
//   BG, BR                          : bus grant / bus request
//   mem_ready, mem_write, mem_addr  : block write handshake towards memory
//   offset                          : device word offset of the current block
//   busy, dma_end_interrupt         : status and completion pulse
// -----------------------------------------------------------------------------
interface dma_block_controller_if #(
   parameter int WORD_SIZE = 16
);
   logic                 cmd_valid;
   logic [WORD_SIZE-1:0] cmd_addr;
   logic [WORD_SIZE-1:0] cmd_length;
   logic                 BG;
   logic                 mem_ready;
   logic                 BR;
   logic [WORD_SIZE-1:0] offset;
   logic [WORD_SIZE-1:0] mem_addr;
   logic                 mem_write;
   logic                 busy;
   logic                 dma_end_interrupt;

   modport master (
      input  cmd_valid, cmd_addr, cmd_length, BG, mem_ready,
      output BR, offset, mem_addr, mem_write, busy, dma_end_interrupt
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_length, BG, mem_ready,
      input  BR, offset, mem_addr, mem_write, busy, dma_end_interrupt
   );
endinterface

// File: rtl/dma_block_controller.sv
// -----------------------------------------------------------------------------
// dma_block_controller
// Sequences a device-to-memory DMA transfer one block of BLOCK_WORDS words at a
// time. A CPU command latches base address and length (rounded down to whole
// blocks); the controller then requests the bus, and for every block drives the
// memory address, the device offset and a write strobe until memory reports
// the block done. Data never passes through this block.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : dma_block_controller_if.master (command, BR/BG, memory handshake,
//           busy, dma_end_interrupt)
// All outputs are registered: each is computed from the next state and next
// count, so it is valid in the same cycle as the state it belongs to.
// -----------------------------------------------------------------------------
module dma_block_controller #(
   parameter int WORD_SIZE   = 16,
   parameter int BLOCK_WORDS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   dma_block_controller_if.master bus
);

   localparam logic [WORD_SIZE-1:0] BLK_INC  = WORD_SIZE'(BLOCK_WORDS);
   // Clears the low bits so only whole blocks are transferred.
   localparam logic [WORD_SIZE-1:0] BLK_MASK = ~(BLK_INC - {{(WORD_SIZE-1){1'b0}}, 1'b1});
   localparam logic [WORD_SIZE-1:0] ZERO_W   = {WORD_SIZE{1'b0}};

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_XFER = 3'd2,
      ST_GAP  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t               state_r, state_s;
   logic [WORD_SIZE-1:0] base_r, base_s;
   logic [WORD_SIZE-1:0] len_r, len_s;
   logic [WORD_SIZE-1:0] count_r, count_s;
   logic [WORD_SIZE-1:0] trunc_len_s;
   logic [WORD_SIZE-1:0] count_inc_s;

   logic                 br_r, br_s;
   logic                 mem_write_r, mem_write_s;
   logic [WORD_SIZE-1:0] mem_addr_r, mem_addr_s;
   logic [WORD_SIZE-1:0] offset_r, offset_s;
   logic                 busy_r, busy_s;
   logic                 end_irq_r, end_irq_s;

   // Next-state and transfer bookkeeping (base, len, count).
   always_comb begin
      state_s     = state_r;
      base_s      = base_r;
      len_s       = len_r;
      count_s     = count_r;
      trunc_len_s = bus.cmd_length & BLK_MASK;
      count_inc_s = count_r + BLK_INC;
      case (state_r)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               base_s  = bus.cmd_addr;
               len_s   = trunc_len_s;
               count_s = ZERO_W;
               // A length shorter than one block completes without using the bus.
               if (trunc_len_s == ZERO_W) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_REQ;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (bus.BG) begin
               state_s = ST_XFER;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_XFER: begin
            // Losing the grant wins over a simultaneous mem_ready: the block is
            // not counted and is rewritten once the grant returns.
            if (!bus.BG) begin
               state_s = ST_REQ;
            end else if (bus.mem_ready) begin
               count_s = count_inc_s;
               if (count_inc_s == len_r) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_GAP;
               end
            end else begin
               state_s = ST_XFER;
            end
         end
         ST_GAP: begin
            if (bus.BG) begin
               state_s = ST_XFER;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Output values for the upcoming state, registered below.
   always_comb begin
      br_s        = 1'b0;
      mem_write_s = 1'b0;
      busy_s      = 1'b1;
      end_irq_s   = 1'b0;
      mem_addr_s  = base_s + count_s;
      offset_s    = count_s;
      case (state_s)
         ST_IDLE: begin
            busy_s = 1'b0;
         end
         ST_REQ: begin
            br_s = 1'b1;
         end
         ST_XFER: begin
            br_s        = 1'b1;
            mem_write_s = 1'b1;
         end
         ST_GAP: begin
            br_s = 1'b1;
         end
         ST_DONE: begin
            end_irq_s = 1'b1;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // State, bookkeeping and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         base_r      <= ZERO_W;
         len_r       <= ZERO_W;
         count_r     <= ZERO_W;
         br_r        <= 1'b0;
         mem_write_r <= 1'b0;
         mem_addr_r  <= ZERO_W;
         offset_r    <= ZERO_W;
         busy_r      <= 1'b0;
         end_irq_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         base_r      <= base_s;
         len_r       <= len_s;
         count_r     <= count_s;
         br_r        <= br_s;
         mem_write_r <= mem_write_s;
         mem_addr_r  <= mem_addr_s;
         offset_r    <= offset_s;
         busy_r      <= busy_s;
         end_irq_r   <= end_irq_s;
      end
   end

   assign bus.BR                = br_r;
   assign bus.mem_write         = mem_write_r;
   assign bus.mem_addr          = mem_addr_r;
   assign bus.offset            = offset_r;
   assign bus.busy              = busy_r;
   assign bus.dma_end_interrupt = end_irq_r;

endmodule

// File: doc/dma_block_controller.md
Name: dma_block_controller

Overview:
- Sequences a DMA transfer from the external device into main memory, one 4-word block at a time.
- Started by a CPU command, issued after the device's dma_begin_interrupt: base address plus word count.
- Obtains the bus through BR/BG and drives the device word offset plus the memory address/write strobe for each block.
- The 64-bit device data goes straight to memory while BG is high; this block never touches data.
- Sits between CPU, memory and external device; signals completion with dma_end_interrupt.

Parameters:
- WORD_SIZE, 16, width of addresses, offsets and lengths.
- BLOCK_WORDS, 4, words moved per memory write; must be a power of two.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  one-cycle DMA start command from CPU.
- cmd_addr  input  WORD_SIZE  destination memory base address.
- cmd_length  input  WORD_SIZE  transfer length in words.
- BG  input  1  bus grant from CPU.
- mem_ready  input  1  memory has completed the current block write.
- BR  output  1  bus request to CPU.
- offset  output  WORD_SIZE  device word offset of current block.
- mem_addr  output  WORD_SIZE  memory address of current block.
- mem_write  output  1  block write request to memory.
- busy  output  1  high in any state other than IDLE.
- dma_end_interrupt  output  1  one-cycle completion pulse to CPU.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- All outputs are registered.
- Reset: at any edge with reset=1, all outputs go to 0, count to 0, state to IDLE. This includes reset mid-transfer; no interrupt is issued for an aborted transfer.
- Internal registers: base (WORD_SIZE), len (WORD_SIZE), count (WORD_SIZE, in words).
- IDLE:
  - On cmd_valid: latch base=cmd_addr, len={cmd_length[15:2],2'b00} (partial trailing block dropped), count=0.
  - If the truncated len is 0, go to DONE. No BR is raised.
  - Otherwise go to REQ.
  - cmd_valid outside IDLE is ignored.
- REQ:
  - BR=1, mem_write=0.
  - Stay while BG=0. On BG=1, go to XFER.
  - Latency: cmd_valid at edge n gives BR=1 after edge n; BG sampled 1 at edge k gives mem_write=1 after edge k.
- XFER:
  - BR=1, mem_write=1, mem_addr=base+count (mod 2^16), offset=count.
  - On mem_ready=1 (with BG=1): count+=BLOCK_WORDS. If the new count==len, go to DONE; else go to GAP.
  - On BG=0 (grant withdrawn): mem_write=0, count unchanged, go to REQ. The current block is retried once the grant returns. BG=0 takes priority over a simultaneous mem_ready, and that block is not counted.
- GAP:
  - One cycle with mem_write=0 and BR held 1, so memory sees distinct requests.
  - mem_addr and offset update to the next block.
  - Next state: XFER if BG=1, else REQ.
- DONE:
  - BR=0, mem_write=0, dma_end_interrupt=1 for exactly one cycle.
  - Then IDLE with busy=0. A new command is accepted from the next cycle.
- Address arithmetic wraps modulo 2^16 (base=16'hFFFE, count=4 → mem_addr=16'h0002). offset never wraps in legal use (len ≤ 2^16−4).
- mem_ready is ignored outside XFER.
- BR never rises while in IDLE or DONE.

Test Plan:
- Basic: cmd_addr=16'h01F4, cmd_length=12, BG=1 two cycles after BR, mem_ready 3 cycles after each mem_write → three writes at mem_addr 01F4/01F8/01FC with offset 0/4/8. mem_write low for one cycle between writes. One dma_end_interrupt pulse, then BR=0 and busy=0.
- Zero/truncated length: cmd_length=3 → no BR, dma_end_interrupt one cycle after cmd_valid. cmd_length=6 → exactly one block written.
- Grant withdrawn: BG drops during the 2nd XFER before mem_ready → mem_write=0 and BR stays 1. When BG returns, mem_addr=base+4 is written again; total 3 completed blocks.
- Simultaneous: mem_ready=1 and BG=0 on the same edge → block not counted, controller re-enters REQ with count unchanged.
- Wrap: cmd_addr=16'hFFFC, cmd_length=8 → mem_addr FFFC then 0000.
- Reset mid-XFER, and cmd_valid while busy: synchronous reset gives BR/mem_write/busy=0 the next cycle with no interrupt. A second cmd_valid during a transfer leaves base and len unchanged.
